// File: rtl/btn_event_decoder_pkg.sv
// Shared state and event encodings for the button gesture decoder.
// The state values are fixed so debug logic can decode state_o directly.
package btn_event_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_HOLD   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4
    } btn_state_e;

    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_SHORT  = 3'd1,
        EV_LONG   = 3'd2,
        EV_REPEAT = 3'd3,
        EV_DOUBLE = 3'd4
    } btn_event_e;

    // A timed phase needs at least two cycles so that its terminal count differs from entry.
    function automatic bit cyc_legal(input int unsigned cyc, input int unsigned cnt_w);
        return (cyc >= 2) && (longint'(cyc - 1) < (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into short/long/repeat/double-click pulses.
// Pulses are registered, one cycle wide and mutually exclusive by construction.
module btn_event_decoder
    import btn_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_CYC = 100_000_000,
    parameter int unsigned DBL_CYC  = 30_000_000,
    parameter int unsigned RPT_CYC  = 20_000_000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level_in,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_tick,
    output logic       double_click,
    output logic [2:0] state_o
);

    if (!cyc_legal(LONG_CYC, CNT_W) || !cyc_legal(DBL_CYC, CNT_W) || !cyc_legal(RPT_CYC, CNT_W)) begin : g_param_check
        $error("btn_event_decoder: *_CYC must be >= 2 and CNT_W must hold *_CYC-1");
    end

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(RPT_CYC - 1);

    btn_state_e       state_q, state_d;
    btn_event_e       ev_q, ev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             rise, fall;

    assign rise = level_in & ~prev_q;
    assign fall = ~level_in & prev_q;

    // Edges are tested before terminal counts so an edge always wins a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ev_d    = EV_NONE;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_GAP;
                end else if (cnt_q == LONG_TC) begin
                    ev_d    = EV_LONG;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == RPT_TC) begin
                    ev_d  = EV_REPEAT;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                end else if (cnt_q == DBL_TC) begin
                    ev_d    = EV_SHORT;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    ev_d    = EV_DOUBLE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // prev resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b1;
            ev_q    <= EV_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_in;
            ev_q    <= ev_d;
        end
    end

    assign short_press  = (ev_q == EV_SHORT);
    assign long_press   = (ev_q == EV_LONG);
    assign repeat_tick  = (ev_q == EV_REPEAT);
    assign double_click = (ev_q == EV_DOUBLE);
    assign state_o      = state_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench: a time-based gesture model predicts each pulse and its cycle,
// a negedge monitor pops and compares whatever the decoder emits.
module tb_btn_event_decoder;

    localparam int LONG = 20;
    localparam int DBL  = 10;
    localparam int RPT  = 5;

    localparam int K_SHORT  = 1;
    localparam int K_LONG   = 2;
    localparam int K_REPEAT = 3;
    localparam int K_DOUBLE = 4;

    localparam int M_IDLE   = 0;
    localparam int M_FIRST  = 1;
    localparam int M_GAP    = 2;
    localparam int M_SECOND = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       level_in = 1'b1;
    logic       short_press, long_press, repeat_tick, double_click;
    logic [2:0] state_o;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    btn_event_decoder #(
        .LONG_CYC(LONG),
        .DBL_CYC (DBL),
        .RPT_CYC (RPT),
        .CNT_W   (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .level_in    (level_in),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_tick (repeat_tick),
        .double_click(double_click),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: gestures judged by elapsed time since the press or release that started them.
    int   m_mode = M_IDLE;
    int   m_t0 = 0;
    logic m_prev = 1'b1;

    always @(posedge clk) begin : ref_model
        int   n, age;
        logic rise, fall;
        n = cyc;
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_prev = 1'b1;
        end else begin
            rise   = level_in & !m_prev;
            fall   = !level_in & m_prev;
            m_prev = level_in;
            age    = n - m_t0;
            case (m_mode)
                M_IDLE: if (rise) begin m_mode = M_FIRST; m_t0 = n; end
                M_FIRST: begin
                    if (fall) begin
                        if (age <= LONG) begin m_mode = M_GAP; m_t0 = n; end
                        else m_mode = M_IDLE;
                    end else if (age == LONG) begin
                        q.push_back(exp_t'{n, K_LONG});
                    end else if (age > LONG && (age - LONG) % RPT == 0) begin
                        q.push_back(exp_t'{n, K_REPEAT});
                    end
                end
                M_GAP: begin
                    if (rise) m_mode = M_SECOND;
                    else if (age == DBL) begin
                        q.push_back(exp_t'{n, K_SHORT});
                        m_mode = M_IDLE;
                    end
                end
                M_SECOND: if (fall) begin
                    q.push_back(exp_t'{n, K_DOUBLE});
                    m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        int   stamp, nhigh, got;
        exp_t e;
        stamp = cyc - 1;
        nhigh = int'(short_press) + int'(long_press) + int'(repeat_tick) + int'(double_click);
        got   = short_press ? K_SHORT : long_press ? K_LONG : repeat_tick ? K_REPEAT :
                double_click ? K_DOUBLE : 0;
        if (nhigh > 1) begin
            total++;
            bad++;
            $display("FAIL exclusive: %0d outputs high at cycle %0d, required at most 1", nhigh, stamp);
        end else if (nhigh == 1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected: kind %0d at cycle %0d, required no pulse", got, stamp);
            end else begin
                e = q.pop_front();
                if (e.kind != got || e.cyc != stamp) begin
                    bad++;
                    $display("FAIL event: kind %0d at cycle %0d, required kind %0d at cycle %0d",
                             got, stamp, e.kind, e.cyc);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= stamp) begin
            total++;
            bad++;
            e = q.pop_front();
            $display("FAIL missing: no pulse at cycle %0d, required kind %0d at cycle %0d",
                     stamp, e.kind, e.cyc);
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        level_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("state_o_after_reset", int'(state_o), 0);
        check("pulses_after_reset",
              int'(short_press) + int'(long_press) + int'(repeat_tick) + int'(double_click), 0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        // held through reset, then released: no gesture
        hold(1'b1, 10);
        hold(1'b0, 50);
        // short press
        hold(1'b1, 5);
        hold(1'b0, 30);
        // double click
        hold(1'b1, 3);
        hold(1'b0, 4);
        hold(1'b1, 3);
        hold(1'b0, 30);
        // long press with repeats
        hold(1'b1, 40);
        hold(1'b0, 30);
        // release on the long-press terminal cycle
        hold(1'b1, LONG);
        hold(1'b0, 30);
        // release on the double-click window terminal cycle
        hold(1'b1, 4);
        hold(1'b0, DBL);
        hold(1'b1, 3);
        hold(1'b0, 30);
        // reset during hold, release ignored, then a fresh short press
        hold(1'b1, 30);
        reset_pulse();
        hold(1'b1, 5);
        hold(1'b0, 30);
        hold(1'b1, 5);
        hold(1'b0, 30);
        // randomized gestures with occasional mid-gesture resets
        for (int i = 0; i < 60; i++) begin
            hold(1'b1, int'($urandom_range(1, 35)));
            if ($urandom_range(0, 7) == 0) reset_pulse();
            hold(1'b0, int'($urandom_range(1, 25)));
        end
        hold(1'b0, 40);
        check("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
